// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet source: FSM states, header field widths
// and the header packing rule.
package router_pkg;

  localparam int ADDR_W   = 2;
  localparam int LEN_W    = 6;
  localparam int NUM_DEST = 3;
  localparam int HDR_W    = LEN_W + ADDR_W;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_COLLECT,
    TX_HEADER,
    TX_PAYLOAD,
    TX_PARITY,
    TX_GAP
  } tx_state_e;

  // Header byte carries the payload length above the destination address.
  function automatic logic [HDR_W-1:0] calc_header(input logic [LEN_W-1:0]  len,
                                                   input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
    return int'(addr) < NUM_DEST;
  endfunction

endpackage

// File: rtl/router_pkt_tx_buf.sv
// Payload store for one packet: synchronous FIFO with a combinational head read so the
// oldest byte is visible on the same cycle it becomes the front entry.
module tx_payload_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally at DEPTH; the occupancy count disambiguates full from empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers a full payload, then sends header, payload and
// parity under router busy back-pressure, followed by an error-sampling gap.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              busy,
  input  logic              err,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              pkt_done,
  output logic              pkt_err,
  output logic              req_drop
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  tx_state_e         state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [DATA_W-1:0] parity_q, parity_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              err_acc_q, err_acc_d;
  logic              drop_q, drop_d;

  logic              buf_push, buf_pop, buf_empty, buf_full;
  logic [DATA_W-1:0] buf_head;

  tx_payload_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_LEN + 1)
  ) u_buf (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .data_i  (pl_data),
    .head_o  (buf_head),
    .empty_o (buf_empty),
    .full_o  (buf_full)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    parity_d  = parity_q;
    gap_d     = gap_q;
    err_acc_d = err_acc_q;
    drop_d    = 1'b0;
    req_ready = 1'b0;
    pl_ready  = 1'b0;
    pkt_valid = 1'b0;
    data_out  = '0;
    pkt_done  = 1'b0;
    pkt_err   = 1'b0;
    buf_push  = 1'b0;
    buf_pop   = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_len == '0 || !addr_legal(req_addr) || int'(req_len) > MAX_LEN) begin
            drop_d = 1'b1;
          end else begin
            len_d    = req_len;
            hdr_d    = DATA_W'(calc_header(req_len, req_addr));
            parity_d = DATA_W'(calc_header(req_len, req_addr));
            cnt_d    = '0;
            state_d  = TX_COLLECT;
          end
        end
      end

      // Payload is fully buffered before anything is offered to the router.
      TX_COLLECT: begin
        pl_ready = !buf_full;
        if (pl_valid && !buf_full) begin
          buf_push = 1'b1;
          parity_d = parity_q ^ pl_data;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == len_q) begin
            cnt_d   = '0;
            state_d = TX_HEADER;
          end
        end
      end

      TX_HEADER: begin
        pkt_valid = 1'b1;
        data_out  = hdr_q;
        if (!busy) state_d = TX_PAYLOAD;
      end

      TX_PAYLOAD: begin
        pkt_valid = 1'b1;
        data_out  = buf_head;
        if (!busy) begin
          buf_pop = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == len_q) begin
            cnt_d   = '0;
            state_d = TX_PARITY;
          end
        end
      end

      TX_PARITY: begin
        data_out = parity_q;
        if (!busy) begin
          gap_d     = '0;
          err_acc_d = 1'b0;
          state_d   = TX_GAP;
        end
      end

      // The router flags parity errors a little after the parity byte, so err is
      // collected over the whole gap, including its final cycle.
      TX_GAP: begin
        err_acc_d = err_acc_q | err;
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          pkt_done = 1'b1;
          pkt_err  = err_acc_q | err;
          state_d  = TX_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= TX_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      hdr_q     <= '0;
      parity_q  <= '0;
      gap_q     <= '0;
      err_acc_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      parity_q  <= parity_d;
      gap_q     <= gap_d;
      err_acc_q <= err_acc_d;
      drop_q    <= drop_d;
    end
  end

  assign req_drop = drop_q;

  always_ff @(posedge clk) begin
    if (rst && state_q == TX_GAP && state_d == TX_IDLE) begin
      assert (buf_empty);
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: table of directed requests, hand-written reset-abort sequence,
// then randomized packets checked against a byte-list reference model.
module tb_router_pkt_tx;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       pl_valid, pl_ready;
  logic [7:0] pl_data;
  logic       busy, err;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       pkt_done, pkt_err, req_drop;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pay [64];

  typedef struct {
    logic [1:0] addr;
    logic [5:0] len;
    bit         drop;
    logic [7:0] hdr;
    int         busy_mode;
    bit         gaps;
    bit         err_gap;
    bit         err_early;
    int         pat;
  } vec_t;

  vec_t tbl [8];

  router_pkt_tx #(.DATA_W(8), .MAX_LEN(63), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_data   (pl_data),
    .busy      (busy),
    .err       (err),
    .pkt_valid (pkt_valid),
    .data_out  (data_out),
    .pkt_done  (pkt_done),
    .pkt_err   (pkt_err),
    .req_drop  (req_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [1:0] addr, input logic [5:0] len, input bit exp_drop);
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
    req_addr  = 2'($urandom);
    req_len   = 6'($urandom);
    @(negedge clk);
    check("req_drop", req_drop, exp_drop);
    check("req_ready_after_req", req_ready, exp_drop);
    check("pl_ready_after_req", pl_ready, !exp_drop);
    check("pkt_valid_after_req", pkt_valid, 0);
    tick();
    if (exp_drop) begin
      @(negedge clk);
      check("req_drop_one_cycle", req_drop, 0);
      check("idle_after_drop", req_ready, 1);
      check("no_pkt_after_drop", pkt_valid, 0);
      tick();
    end
  endtask

  task automatic send_payload(input int len, input bit gaps, input bit junk_req);
    int i = 0;
    int guard = 0;
    while (i < len && guard < 5000) begin
      pl_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      pl_data   = pay[i];
      req_valid = junk_req ? 1'($urandom_range(0, 1)) : 1'b0;
      req_addr  = 2'd3;
      req_len   = 6'd0;
      @(negedge clk);
      check("pl_ready_collect", pl_ready, 1);
      check("req_ready_collect", req_ready, 0);
      check("pkt_valid_collect", pkt_valid, 0);
      if (pl_valid && pl_ready) i++;
      tick();
      guard++;
    end
    pl_valid  = 1'b0;
    req_valid = 1'b0;
    if (guard >= 5000) fail_now("payload_accept");
    else begin
      @(negedge clk);
      check("req_drop_ignored_busy", req_drop, 0);
      // already mid-cycle: emit_check resumes from here on the next negedge of this cycle
    end
  endtask

  // Reference model: the transfer list is header, payload bytes, then XOR of all of them.
  task automatic emit_check(input logic [1:0] addr, input logic [5:0] len, input int busy_mode,
                            input bit err_gap, input bit err_early,
                            input bit chk_tbl, input logic [7:0] hdr_tbl);
    logic [7:0] exp_b [66];
    logic [7:0] par;
    int idx = 0;
    int cyc = 0;
    int hold = 0;
    exp_b[0] = {len, addr};
    par = exp_b[0];
    for (int k = 0; k < int'(len); k++) begin
      exp_b[k+1] = pay[k];
      par ^= pay[k];
    end
    exp_b[int'(len)+1] = par;

    // first sample is in the current cycle (header is due right after the last accept)
    busy = 1'b0;
    err  = 1'b0;
    while (idx < int'(len) + 2 && cyc < 5000) begin
      if (cyc > 0) begin
        busy = (busy_mode == 1) ? ($urandom_range(0, 3) == 0)
                                : (busy_mode == 2 && idx == 2 && hold < 4);
        err  = err_early ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end else begin
        busy = (busy_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
        err  = err_early ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
      end
      check("data_out", data_out, exp_b[idx]);
      check("pkt_valid", pkt_valid, idx <= int'(len));
      check("pkt_done_early", pkt_done, 0);
      check("req_ready_tx", req_ready, 0);
      if (chk_tbl && idx == 0) check("tbl_header", data_out, hdr_tbl);
      if (busy) hold++;
      else idx++;
      tick();
      cyc++;
    end
    if (cyc >= 5000) fail_now("emit_transfer");

    for (int g = 0; g < GAP; g++) begin
      busy = 1'($urandom);
      err  = err_gap && g == 0;
      @(negedge clk);
      check("gap_data_out", data_out, 0);
      check("gap_pkt_valid", pkt_valid, 0);
      check("pkt_done", pkt_done, g == GAP - 1);
      check("pkt_err", pkt_err, (g == GAP - 1) && err_gap);
      tick();
    end
    err  = 1'b0;
    busy = 1'b0;
    @(negedge clk);
    check("idle_after_pkt", req_ready, 1);
    check("pkt_done_one_cycle", pkt_done, 0);
    tick();
  endtask

  task automatic fill_pay(input int pat, input int len);
    for (int k = 0; k < len; k++) begin
      case (pat)
        1:       pay[k] = (k == 0) ? 8'hA5 : (k == 1) ? 8'h3C : 8'hFF;
        2:       pay[k] = 8'(k);
        default: pay[k] = 8'($urandom);
      endcase
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
    pl_valid = 1'b0; pl_data = '0; busy = 1'b0; err = 1'b0;

    tbl[0] = '{2'd1, 6'd3,  1'b0, 8'h0D, 0, 1'b0, 1'b0, 1'b0, 1};
    tbl[1] = '{2'd1, 6'd3,  1'b0, 8'h0D, 2, 1'b0, 1'b0, 1'b0, 1};
    tbl[2] = '{2'd0, 6'd0,  1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 0};
    tbl[3] = '{2'd3, 6'd5,  1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 0};
    tbl[4] = '{2'd0, 6'd63, 1'b0, 8'hFC, 0, 1'b1, 1'b0, 1'b0, 2};
    tbl[5] = '{2'd2, 6'd1,  1'b0, 8'h06, 0, 1'b0, 1'b1, 1'b0, 0};
    tbl[6] = '{2'd2, 6'd4,  1'b0, 8'h12, 1, 1'b1, 1'b0, 1'b1, 0};
    tbl[7] = '{2'd3, 6'd0,  1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 0};

    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_pl_ready", pl_ready, 0);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_pkt_err", pkt_err, 0);
    check("rst_req_drop", req_drop, 0);
    tick();
    rst = 1'b1;
    tick();

    for (int t = 0; t < 8; t++) begin
      if (tbl[t].drop) begin
        send_req(tbl[t].addr, tbl[t].len, 1'b1);
      end else begin
        fill_pay(tbl[t].pat, int'(tbl[t].len));
        send_req(tbl[t].addr, tbl[t].len, 1'b0);
        send_payload(int'(tbl[t].len), tbl[t].gaps, 1'b1);
        emit_check(tbl[t].addr, tbl[t].len, tbl[t].busy_mode, tbl[t].err_gap,
                   tbl[t].err_early, 1'b1, tbl[t].hdr);
      end
    end

    // Reset while the second of five payload bytes is on the bus.
    fill_pay(0, 5);
    send_req(2'd1, 6'd5, 1'b0);
    send_payload(5, 1'b0, 1'b0);
    busy = 1'b0;
    #1;
    check("abort_header", data_out, 8'h15);
    tick();
    @(negedge clk);
    check("abort_byte1", data_out, pay[0]);
    tick();
    @(negedge clk);
    check("abort_byte2", data_out, pay[1]);
    check("abort_valid", pkt_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("async_pkt_valid", pkt_valid, 0);
    check("async_data_out", data_out, 0);
    check("async_req_ready", req_ready, 1);
    check("async_pl_ready", pl_ready, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    fill_pay(0, 2);
    send_req(2'd2, 6'd2, 1'b0);
    send_payload(2, 1'b1, 1'b0);
    emit_check(2'd2, 6'd2, 0, 1'b0, 1'b0, 1'b0, 8'h00);

    for (int r = 0; r < 12; r++) begin
      logic [1:0] a;
      logic [5:0] l;
      if ($urandom_range(0, 4) == 0) begin
        send_req(2'd3, 6'($urandom_range(0, 63)), 1'b1);
      end
      a = 2'($urandom_range(0, 2));
      l = 6'($urandom_range(1, 63));
      fill_pay(0, int'(l));
      send_req(a, l, 1'b0);
      send_payload(int'(l), 1'b1, 1'b1);
      emit_check(a, l, 1, 1'($urandom), 1'($urandom), 1'b0, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
